ysyx_bus_arbiter: RTL and testbench

- Shares the single memory port between the instruction fetch unit (IFU read) and the load/store unit (LSU read or write).
- Sits between ysyx_IFU/ysyx_LSU and the memory/bus bridge.
- Accepts level-held requests, grants round-robin, and keeps one transaction outstanding at a time.
- Returns a one-cycle response pulse to the granted requester only.

---
 rtl/ysyx_bus_arbiter_if.sv | 46 ++++
 rtl/ysyx_bus_arbiter.sv | 100 ++++++++++
 tb/tb_ysyx_bus_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_bus_arbiter_if.sv
// ysyx_bus_arbiter_if: IFU/LSU requester and memory-port signals; master = arbiter view, slave = environment view
interface ysyx_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] ifu_araddr;
  logic              ifu_arvalid;
  logic [DATA_W-1:0] ifu_rdata;
  logic              ifu_rvalid;
  logic              ifu_rerr;
  logic [ADDR_W-1:0] lsu_araddr;
  logic              lsu_arvalid;
  logic [7:0]        lsu_rstrb;
  logic [DATA_W-1:0] lsu_rdata;
  logic              lsu_rvalid;
  logic [ADDR_W-1:0] lsu_awaddr;
  logic              lsu_awvalid;
  logic [DATA_W-1:0] lsu_wdata;
  logic [7:0]        lsu_wstrb;
  logic              lsu_wvalid;
  logic              lsu_wready;
  logic              lsu_err;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        mem_strb;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_rdata;
  logic              mem_rsp_err;
  modport master (
    input  ifu_araddr, ifu_arvalid, lsu_araddr, lsu_arvalid, lsu_rstrb,
           lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
    output ifu_rdata, ifu_rvalid, ifu_rerr, lsu_rdata, lsu_rvalid, lsu_wready, lsu_err,
           mem_req_valid, mem_req_wen, mem_addr, mem_wdata, mem_strb
  );
  modport slave (
    output ifu_araddr, ifu_arvalid, lsu_araddr, lsu_arvalid, lsu_rstrb,
           lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
    input  ifu_rdata, ifu_rvalid, ifu_rerr, lsu_rdata, lsu_rvalid, lsu_wready, lsu_err,
           mem_req_valid, mem_req_wen, mem_addr, mem_wdata, mem_strb
  );
endinterface

// File: rtl/ysyx_bus_arbiter.sv
// ysyx_bus_arbiter: round-robin IFU/LSU arbiter onto one memory port, one transaction outstanding (clk, rst async active-low, bus = ysyx_bus_arbiter_if.master; optional ARB_TIMEOUT_EN)
module ysyx_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst,
  ysyx_bus_arbiter_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  localparam logic [1:0] OWN_IFU = 2'd0, OWN_LD = 2'd1, OWN_ST = 2'd2;
  logic [1:0] state_q, state_d, own_q, own_d;
  logic last_lsu_q, last_lsu_d, req_valid_q, req_valid_d, wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata;
  logic [7:0] strb_q, strb_d;
  logic st_req, lsu_req, grant, grant_ifu, busy, rsp_live, to_fire, fire, err;
  assign st_req = bus.lsu_awvalid & bus.lsu_wvalid;
  assign lsu_req = st_req | bus.lsu_arvalid;
  assign grant = state_q == IDLE && (bus.ifu_arvalid || lsu_req);
  // last_lsu_q resets to 1 so the IFU wins the first tie
  assign grant_ifu = bus.ifu_arvalid & (!lsu_req | last_lsu_q);
  assign busy = state_q == REQ || state_q == WAIT;
  // a response only counts once the request has been accepted (same cycle allowed)
  assign rsp_live = bus.mem_rsp_valid && (state_q == WAIT || (state_q == REQ && bus.mem_req_ready));
`ifdef ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  assign to_fire = busy && !rsp_live && cnt_q == 16'(TIMEOUT_CYCLES);
  assign cnt_d = grant ? '0 : busy ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign to_fire = 1'b0;
`endif
  assign fire = rsp_live | to_fire;
  assign err = to_fire | bus.mem_rsp_err;
  assign rdata = to_fire ? '0 : bus.mem_rsp_rdata;
  always_comb begin
    state_d = state_q;
    own_d = own_q;
    last_lsu_d = last_lsu_q;
    req_valid_d = req_valid_q;
    wen_d = wen_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    strb_d = strb_q;
    if (grant) begin
      state_d = REQ;
      req_valid_d = 1'b1;
      last_lsu_d = !grant_ifu;
      own_d = grant_ifu ? OWN_IFU : st_req ? OWN_ST : OWN_LD;
      wen_d = !grant_ifu && st_req;
      addr_d = grant_ifu ? bus.ifu_araddr : st_req ? bus.lsu_awaddr : bus.lsu_araddr;
      wdata_d = (!grant_ifu && st_req) ? bus.lsu_wdata : '0;
      strb_d = grant_ifu ? 8'h0F : st_req ? bus.lsu_wstrb : bus.lsu_rstrb;
    end else if (fire) begin
      state_d = DONE;
      req_valid_d = 1'b0;
    end else if (state_q == REQ && bus.mem_req_ready) begin
      state_d = WAIT;
      req_valid_d = 1'b0;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      own_q <= OWN_IFU;
      last_lsu_q <= 1'b1;
      req_valid_q <= 1'b0;
      wen_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      strb_q <= '0;
    end else begin
      state_q <= state_d;
      own_q <= own_d;
      last_lsu_q <= last_lsu_d;
      req_valid_q <= req_valid_d;
      wen_q <= wen_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      strb_q <= strb_d;
    end
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_wen = wen_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_strb = strb_q;
  assign bus.ifu_rvalid = fire && own_q == OWN_IFU;
  assign bus.lsu_rvalid = fire && own_q == OWN_LD;
  assign bus.lsu_wready = fire && own_q == OWN_ST;
  assign bus.ifu_rerr = bus.ifu_rvalid & err;
  assign bus.lsu_err = fire && own_q != OWN_IFU && err;
  assign bus.ifu_rdata = bus.ifu_rvalid ? rdata : '0;
  assign bus.lsu_rdata = bus.lsu_rvalid ? rdata : '0;
endmodule

// File: tb/tb_ysyx_bus_arbiter.sv
// tb_ysyx_bus_arbiter: directed self-checking bench for ysyx_bus_arbiter
module tb_ysyx_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  ysyx_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();
  ysyx_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic round(input logic [31:0] exp_addr, input logic exp_ifu, input logic [31:0] rd);
    cyc();
    #1;
    chk("rr_valid", 64'(bus.mem_req_valid), 64'd1);
    chk("rr_addr", 64'(bus.mem_addr), 64'(exp_addr));
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = rd;
    bus.mem_rsp_err = !exp_ifu;
    #1;
    chk("rr_ifu_rvalid", 64'(bus.ifu_rvalid), 64'(exp_ifu));
    chk("rr_lsu_rvalid", 64'(bus.lsu_rvalid), 64'(!exp_ifu));
    chk("rr_ifu_rdata", 64'(bus.ifu_rdata), exp_ifu ? 64'(rd) : 64'd0);
    chk("rr_lsu_rdata", 64'(bus.lsu_rdata), exp_ifu ? 64'd0 : 64'(rd));
    chk("rr_lsu_err", 64'(bus.lsu_err), 64'(!exp_ifu));
    chk("rr_ifu_rerr", 64'(bus.ifu_rerr), 64'd0);
    cyc();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_err = 1'b0;
    #1;
    chk("rr_done_bubble", 64'(bus.mem_req_valid), 64'd0);
    cyc();
    #1;
    chk("rr_idle_nogrant", 64'(bus.mem_req_valid), 64'd0);
  endtask
  initial begin
    bus.ifu_araddr = '0; bus.ifu_arvalid = 1'b0;
    bus.lsu_araddr = '0; bus.lsu_arvalid = 1'b0; bus.lsu_rstrb = '0;
    bus.lsu_awaddr = '0; bus.lsu_awvalid = 1'b0; bus.lsu_wdata = '0; bus.lsu_wstrb = '0; bus.lsu_wvalid = 1'b0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = '0; bus.mem_rsp_err = 1'b0;
    #3;
    chk("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("rst_wen", 64'(bus.mem_req_wen), 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_strb", 64'(bus.mem_strb), 64'd0);
    chk("rst_rsp", 64'({bus.ifu_rvalid, bus.lsu_rvalid, bus.lsu_wready, bus.ifu_rerr, bus.lsu_err}), 64'd0);
    cyc();
    cyc();
    rst = 1'b1;
    // IFU only
    bus.ifu_araddr = 32'h8000_0000;
    bus.ifu_arvalid = 1'b1;
    cyc();
    #1;
    chk("ifu_req_valid", 64'(bus.mem_req_valid), 64'd1);
    chk("ifu_addr", 64'(bus.mem_addr), 64'h8000_0000);
    chk("ifu_wen", 64'(bus.mem_req_wen), 64'd0);
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 32'h0000_0413;
    #1;
    chk("ifu_accept_drop", 64'(bus.mem_req_valid), 64'd0);
    chk("ifu_rvalid", 64'(bus.ifu_rvalid), 64'd1);
    chk("ifu_rdata", 64'(bus.ifu_rdata), 64'h0000_0413);
    chk("ifu_lsu_quiet", 64'({bus.lsu_rvalid, bus.lsu_wready, bus.lsu_rdata}), 64'd0);
    cyc();
    bus.mem_rsp_valid = 1'b0;
    bus.ifu_arvalid = 1'b0;
    #1;
    chk("ifu_single_pulse", 64'(bus.ifu_rvalid), 64'd0);
    cyc();
    cyc();
    #1;
    chk("ifu_no_regrant", 64'(bus.mem_req_valid), 64'd0);
    // LSU store, response in the accept cycle
    bus.lsu_awaddr = 32'h8000_1000;
    bus.lsu_wdata = 32'hDEAD_BEEF;
    bus.lsu_wstrb = 8'h0F;
    bus.lsu_awvalid = 1'b1;
    bus.lsu_wvalid = 1'b1;
    bus.lsu_araddr = 32'h8000_5555;
    bus.lsu_arvalid = 1'b1;
    cyc();
    #1;
    chk("st_valid", 64'(bus.mem_req_valid), 64'd1);
    chk("st_wen", 64'(bus.mem_req_wen), 64'd1);
    chk("st_addr", 64'(bus.mem_addr), 64'h8000_1000);
    chk("st_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
    chk("st_strb", 64'(bus.mem_strb), 64'h0F);
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 32'h1111_2222;
    #1;
    chk("st_wready", 64'(bus.lsu_wready), 64'd1);
    chk("st_others_quiet", 64'({bus.ifu_rvalid, bus.lsu_rvalid, bus.lsu_err}), 64'd0);
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.lsu_awvalid = 1'b0;
    bus.lsu_wvalid = 1'b0;
    bus.lsu_arvalid = 1'b0;
    #1;
    chk("st_done_state", 64'({bus.mem_req_valid, bus.lsu_wready}), 64'd0);
    cyc();
    // contention from reset: IFU, LSU, IFU
    rst = 1'b0;
    #1;
    rst = 1'b1;
    bus.ifu_araddr = 32'h8000_0100;
    bus.ifu_arvalid = 1'b1;
    bus.lsu_araddr = 32'h8000_2000;
    bus.lsu_rstrb = 8'h03;
    bus.lsu_arvalid = 1'b1;
    round(32'h8000_0100, 1'b1, 32'hA000_0001);
    round(32'h8000_2000, 1'b0, 32'hB000_0002);
    round(32'h8000_0100, 1'b1, 32'hC000_0003);
    bus.ifu_arvalid = 1'b0;
    bus.lsu_arvalid = 1'b0;
    // backpressure: ready low for 5 cycles
    bus.ifu_araddr = 32'h8000_0200;
    bus.ifu_arvalid = 1'b1;
    cyc();
    for (int i = 0; i < 6; i++) begin
      bus.mem_req_ready = (i == 5);
      #1;
      chk("bp_valid", 64'(bus.mem_req_valid), 64'd1);
      chk("bp_addr", 64'(bus.mem_addr), 64'h8000_0200);
      cyc();
    end
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 32'h0000_0BEE;
    #1;
    chk("bp_single_accept", 64'(bus.mem_req_valid), 64'd0);
    chk("bp_rvalid", 64'(bus.ifu_rvalid), 64'd1);
    cyc();
    bus.mem_rsp_valid = 1'b0;
    bus.ifu_arvalid = 1'b0;
    cyc();
    // reset during WAIT
    bus.ifu_araddr = 32'h8000_0300;
    bus.ifu_arvalid = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.ifu_arvalid = 1'b0;
    rst = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    #1;
    chk("rw_addr_zero", 64'(bus.mem_addr), 64'd0);
    chk("rw_rsp_zero", 64'({bus.ifu_rvalid, bus.ifu_rdata}), 64'd0);
    cyc();
    rst = 1'b1;
    #1;
    chk("rw_stale_rsp", 64'({bus.ifu_rvalid, bus.lsu_rvalid}), 64'd0);
    bus.mem_rsp_valid = 1'b0;
    bus.ifu_araddr = 32'h8000_0400;
    bus.ifu_arvalid = 1'b1;
    cyc();
    #1;
    chk("rw_fresh_addr", 64'(bus.mem_addr), 64'h8000_0400);
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 32'h0000_1234;
    #1;
    chk("rw_fresh_rsp", 64'(bus.ifu_rdata), 64'h0000_1234);
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.ifu_arvalid = 1'b0;
    cyc();
    bus.mem_rsp_valid = 1'b1;
    #1;
    chk("idle_rsp_ignored", 64'({bus.ifu_rvalid, bus.lsu_rvalid, bus.lsu_wready}), 64'd0);
    bus.mem_rsp_valid = 1'b0;
`ifdef ARB_TIMEOUT_EN
    bus.lsu_araddr = 32'h8000_3000;
    bus.lsu_arvalid = 1'b1;
    bus.mem_rsp_rdata = 32'h5A5A_5A5A;
    cyc();
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("to_early", 64'(bus.lsu_rvalid), 64'd0);
      cyc();
    end
    #1;
    chk("to_rvalid", 64'(bus.lsu_rvalid), 64'd1);
    chk("to_err", 64'(bus.lsu_err), 64'd1);
    chk("to_rdata", 64'(bus.lsu_rdata), 64'd0);
    cyc();
    bus.lsu_arvalid = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    #1;
    chk("to_late_rsp", 64'(bus.lsu_rvalid), 64'd0);
    bus.mem_rsp_valid = 1'b0;
    cyc();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
